// File: rtl/dh_argmin_select_if.sv
// Handshake/result bundle between the Dh stage driver and the argmin selector.
// The master drives start and Dh samples; the slave returns per-q metrics and
// the sweep result.
interface dh_argmin_select_if #(
   parameter int N     = 32,
   parameter int QW    = 4,
   parameter int ACC_W = N + 4
);
   logic                    start;
   logic signed [N-1:0]     Dh_in;
   logic                    Dh_in_valid;
   logic                    busy;
   logic                    metric_valid;
   logic [QW-1:0]           metric_q;
   logic signed [ACC_W-1:0] metric_out;
   logic                    best_valid;
   logic [QW-1:0]           best_q;
   logic signed [ACC_W-1:0] best_metric;
   logic                    stray_err;

   modport master (
      output start, Dh_in, Dh_in_valid,
      input  busy, metric_valid, metric_q, metric_out,
             best_valid, best_q, best_metric, stray_err
   );

   modport slave (
      input  start, Dh_in, Dh_in_valid,
      output busy, metric_valid, metric_q, metric_out,
             best_valid, best_q, best_metric, stray_err
   );
endinterface

// File: rtl/dh_argmin_select.sv
// Argmin selector after the Hq->Dh pipeline: sums DH_PER_Q Dh samples per
// candidate q, sweeps q = 0..Q-1 and reports the q with the smallest metric
// (lowest q wins ties).
module dh_argmin_select #(
   parameter int N        = 32,
   parameter int Q        = 16,
   parameter int DH_PER_Q = 4,
   parameter int ACC_W    = N + 4,
   parameter int QW       = $clog2(Q)
) (
   input  logic               clk,
   input  logic               rst,
   dh_argmin_select_if.slave  dh_if
);

   localparam int SW = (DH_PER_Q > 1) ? $clog2(DH_PER_Q) : 1;

   typedef enum logic {
      S_IDLE,
      S_ACC
   } state_t;

   state_t                  state_q;
   logic [QW-1:0]           q_cnt_q;
   logic [SW-1:0]           s_cnt_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    busy_q;
   logic                    metric_valid_q;
   logic [QW-1:0]           metric_q_q;
   logic signed [ACC_W-1:0] metric_out_q;
   logic                    best_valid_q;
   logic [QW-1:0]           best_q_q;
   logic signed [ACC_W-1:0] best_metric_q;
   logic                    stray_err_q;

   logic signed [ACC_W-1:0] sum_d;
   logic                    last_sample_d;
   logic                    last_q_d;
   logic                    better_d;

   // Running sum with the incoming sample sign-extended, plus group/sweep end flags.
   always_comb begin
      sum_d         = acc_q + {{(ACC_W-N){dh_if.Dh_in[N-1]}}, dh_if.Dh_in};
      last_sample_d = (s_cnt_q == SW'(DH_PER_Q - 1));
      last_q_d      = (q_cnt_q == QW'(Q - 1));
      better_d      = (q_cnt_q == '0) || (sum_d < best_metric_q);
   end

   // Sweep FSM with all outputs registered; pulses default low every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         q_cnt_q        <= '0;
         s_cnt_q        <= '0;
         acc_q          <= '0;
         busy_q         <= 1'b0;
         metric_valid_q <= 1'b0;
         metric_q_q     <= '0;
         metric_out_q   <= '0;
         best_valid_q   <= 1'b0;
         best_q_q       <= '0;
         best_metric_q  <= '0;
         stray_err_q    <= 1'b0;
      end else begin
         metric_valid_q <= 1'b0;
         best_valid_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (dh_if.start) begin
                  state_q     <= S_ACC;
                  q_cnt_q     <= '0;
                  s_cnt_q     <= '0;
                  acc_q       <= '0;
                  stray_err_q <= 1'b0;
                  busy_q      <= 1'b1;
               end else if (dh_if.Dh_in_valid) begin
                  stray_err_q <= 1'b1;
               end
            end
            S_ACC: begin
               if (dh_if.Dh_in_valid) begin
                  if (!last_sample_d) begin
                     acc_q   <= sum_d;
                     s_cnt_q <= s_cnt_q + 1'b1;
                  end else begin
                     metric_out_q   <= sum_d;
                     metric_q_q     <= q_cnt_q;
                     metric_valid_q <= 1'b1;
                     if (better_d) begin
                        best_metric_q <= sum_d;
                        best_q_q      <= q_cnt_q;
                     end
                     acc_q   <= '0;
                     s_cnt_q <= '0;
                     if (last_q_d) begin
                        best_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                     end else begin
                        q_cnt_q <= q_cnt_q + 1'b1;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dh_if.busy         = busy_q;
   assign dh_if.metric_valid = metric_valid_q;
   assign dh_if.metric_q     = metric_q_q;
   assign dh_if.metric_out   = metric_out_q;
   assign dh_if.best_valid   = best_valid_q;
   assign dh_if.best_q       = best_q_q;
   assign dh_if.best_metric  = best_metric_q;
   assign dh_if.stray_err    = stray_err_q;

endmodule

// File: tb/tb_dh_argmin_select.sv
// Bench for dh_argmin_select: directed sweeps plus random data/bubbles,
// checked against a plain-arithmetic argmin reference.
module tb_dh_argmin_select;
   localparam int N        = 32;
   localparam int Q        = 16;
   localparam int DH_PER_Q = 4;
   localparam int ACC_W    = N + 4;
   localparam int QW       = 4;
   localparam int NS       = Q * DH_PER_Q;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dh_argmin_select_if #(.N(N), .QW(QW), .ACC_W(ACC_W)) bus_if ();

   dh_argmin_select #(
      .N(N), .Q(Q), .DH_PER_Q(DH_PER_Q), .ACC_W(ACC_W), .QW(QW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .dh_if (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   longint sm [NS];
   longint exp_m [Q];
   int     exp_bq;
   longint exp_bm;

   logic [QW-1:0]           mon_q [$];
   logic signed [ACC_W-1:0] mon_m [$];
   int                      best_cnt = 0;

   // Record every metric/best pulse seen by the consumer.
   always @(negedge clk) begin
      if (bus_if.metric_valid === 1'b1) begin
         mon_q.push_back(bus_if.metric_q);
         mon_m.push_back(bus_if.metric_out);
      end
      if (bus_if.best_valid === 1'b1) best_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] m36(input longint v);
      logic [ACC_W-1:0] t;
      t = v[ACC_W-1:0];
      return {28'd0, t};
   endfunction

   // Reference: each metric is the plain sum of its samples; first strict minimum wins.
   task automatic build_model();
      for (int q = 0; q < Q; q++) begin
         exp_m[q] = 0;
         for (int k = 0; k < DH_PER_Q; k++) exp_m[q] += sm[q*DH_PER_Q + k];
      end
      exp_bq = 0;
      exp_bm = exp_m[0];
      for (int q = 1; q < Q; q++)
         if (exp_m[q] < exp_bm) begin
            exp_bq = q;
            exp_bm = exp_m[q];
         end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  {63'd0, bus_if.busy}, 64'd0);
      chk({tag, "_mv"},    {63'd0, bus_if.metric_valid}, 64'd0);
      chk({tag, "_mq"},    {60'd0, bus_if.metric_q}, 64'd0);
      chk({tag, "_mo"},    m36(longint'(bus_if.metric_out)), 64'd0);
      chk({tag, "_bv"},    {63'd0, bus_if.best_valid}, 64'd0);
      chk({tag, "_bq"},    {60'd0, bus_if.best_q}, 64'd0);
      chk({tag, "_bm"},    m36(longint'(bus_if.best_metric)), 64'd0);
      chk({tag, "_stray"}, {63'd0, bus_if.stray_err}, 64'd0);
   endtask

   // One sweep: start pulse, NS samples with optional bubbles, optional
   // extra start at sample start_at, optional async reset before sample rst_at.
   task automatic run_sweep(input string tag, input int maxbub, input int start_at, input int rst_at);
      int nb;
      build_model();
      mon_q.delete();
      mon_m.delete();
      best_cnt = 0;
      bus_if.start = 1'b1;
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      chk({tag, "_busy_start"},  {63'd0, bus_if.busy}, 64'd1);
      chk({tag, "_stray_start"}, {63'd0, bus_if.stray_err}, 64'd0);
      for (int i = 0; i < NS; i++) begin
         if (i == rst_at) begin
            #2 rst = 1'b1;
            #1;
            chk_all_zero({tag, "_midrst"});
            chk({tag, "_no_best_before_rst"}, 64'(best_cnt), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         nb = (maxbub > 0) ? int'($urandom_range(0, maxbub)) : 0;
         repeat (nb) begin
            bus_if.Dh_in_valid = 1'b0;
            @(posedge clk); #1;
         end
         bus_if.Dh_in_valid = 1'b1;
         bus_if.Dh_in       = sm[i][N-1:0];
         if (i == start_at) bus_if.start = 1'b1;
         @(posedge clk); #1;
         bus_if.Dh_in_valid = 1'b0;
         bus_if.start       = 1'b0;
         if (i == NS - 2) begin
            chk({tag, "_busy_mid"}, {63'd0, bus_if.busy}, 64'd1);
            chk({tag, "_no_best_early"}, 64'(best_cnt), 64'd0);
         end
      end
      chk({tag, "_bv_at_end"}, {63'd0, bus_if.best_valid}, 64'd1);
      chk({tag, "_busy_end"},  {63'd0, bus_if.busy}, 64'd0);
      chk({tag, "_best_q"},    {60'd0, bus_if.best_q}, 64'(exp_bq));
      chk({tag, "_best_m"},    m36(longint'(bus_if.best_metric)), m36(exp_bm));
      @(posedge clk); #1;
      chk({tag, "_bv_pulse"},  {63'd0, bus_if.best_valid}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_best_cnt"},  64'(best_cnt), 64'd1);
      chk({tag, "_n_metrics"}, 64'(mon_q.size()), 64'(Q));
      for (int q = 0; q < Q && q < mon_q.size(); q++) begin
         chk($sformatf("%s_mq%0d", tag, q), {60'd0, mon_q[q]}, 64'(q));
         chk($sformatf("%s_mo%0d", tag, q), m36(longint'(mon_m[q])), m36(exp_m[q]));
      end
      chk({tag, "_best_hold_q"}, {60'd0, bus_if.best_q}, 64'(exp_bq));
   endtask

   task automatic fill_t2();
      for (int q = 0; q < Q; q++)
         for (int k = 0; k < DH_PER_Q; k++)
            sm[q*DH_PER_Q + k] = (q == 7) ? 64'sd1 : longint'(100 - 5*q);
   endtask

   initial begin
      bus_if.start       = 1'b0;
      bus_if.Dh_in       = '0;
      bus_if.Dh_in_valid = 1'b0;

      // Asynchronous reset between clock edges clears everything at once.
      #2 rst = 1'b1;
      #1;
      chk_all_zero("t1_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Back-to-back sweep, q=7 smallest.
      fill_t2();
      run_sweep("t2", 0, -1, -1);
      chk("t2_metric_q0", m36(exp_m[0]), m36(64'sd400));
      chk("t2_model_best", 64'(exp_bq), 64'd7);

      // Tie between q=3 and q=9: lower q must win.
      for (int i = 0; i < NS; i++) sm[i] = 10;
      for (int k = 0; k < DH_PER_Q; k++) begin
         sm[3*DH_PER_Q + k] = 2;
         sm[9*DH_PER_Q + k] = 2;
      end
      run_sweep("t3", 0, -1, -1);

      // Most negative samples, no bubbles then random bubbles.
      for (int i = 0; i < NS; i++) sm[i] = 0;
      for (int k = 0; k < DH_PER_Q; k++) sm[5*DH_PER_Q + k] = -64'sd2147483648;
      run_sweep("t4a", 0, -1, -1);
      run_sweep("t4b", 3, -1, -1);

      // Stray samples while idle, then a start pulse mid-sweep that must be ignored.
      bus_if.Dh_in       = 32'd55;
      bus_if.Dh_in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus_if.Dh_in_valid = 1'b0;
      chk("t5_stray_set", {63'd0, bus_if.stray_err}, 64'd1);
      chk("t5_idle_busy", {63'd0, bus_if.busy}, 64'd0);
      chk("t5_no_metric", 64'(mon_q.size()), 64'(Q));
      fill_t2();
      run_sweep("t5", 0, 10, -1);
      chk("t5_stray_after", {63'd0, bus_if.stray_err}, 64'd0);

      // Start coincident with the final sample is ignored.
      run_sweep("t5b", 1, NS - 1, -1);
      @(posedge clk); #1;
      chk("t5b_still_idle", {63'd0, bus_if.busy}, 64'd0);

      // Reset after 20 samples, then a clean sweep.
      run_sweep("t6a", 0, -1, 20);
      chk("t6_idle_after_rst", {63'd0, bus_if.busy}, 64'd0);
      run_sweep("t6b", 0, -1, -1);

      // Random full-range data with random bubbles.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NS; i++) sm[i] = longint'($signed(32'($urandom)));
         run_sweep($sformatf("rnd%0d", r), 2, -1, -1);
      end

      // Random small data to exercise ties.
      for (int i = 0; i < NS; i++) sm[i] = longint'($urandom_range(0, 3)) - 1;
      run_sweep("rnd_tie", 1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
